tsu_queue_merge: RTL

TSU_QUEUE_MERGE -- requirements
Module: tsu_queue_merge

---
 rtl/tsu_queue_merge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/tsu_queue_merge.sv
// tsu_queue_merge: round-robin merge of NUM_CH tsu queues into one FIFO.
// Define TSU_MERGE_TAG_EN to store a 3-bit source tag per record and expose q_rd_chan.
module tsu_queue_merge #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                     q_rd_clk,
  input  logic                     q_rst_n,
  output logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH*8-1:0]      ch_rd_stat,
  input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
  input  logic                     q_rd_en,
  output logic [7:0]               q_rd_stat,
  output logic [DATA_W-1:0]        q_rd_data
`ifdef TSU_MERGE_TAG_EN
  ,
  output logic [2:0]               q_rd_chan
`endif
);
  localparam int AW = $clog2(DEPTH);
`ifdef TSU_MERGE_TAG_EN
  localparam int FW = DATA_W + 3;
`else
  localparam int FW = DATA_W;
`endif
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [FW-1:0]     mem_q [DEPTH];
  logic [7:0]        req;
  logic [3:0]        idx;
  logic [2:0]        pick;
  logic              found, start, wr, pop;
  logic [DATA_W-1:0] sel;
  logic [FW-1:0]     wr_data, head;
`ifdef TSU_MERGE_TAG_EN
  logic [2:0]        chan_q, chan_d;
`endif

  // grant_q doubles as the last grant, so the search starts one past it
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) req[i] = |ch_rd_stat[8*i +: 8];
    found = 1'b0;
    pick = grant_q;
    idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = 4'(grant_q) + 4'(k);
      if (idx >= 4'(NUM_CH)) idx = idx - 4'(NUM_CH);
      if (!found && req[idx[2:0]]) begin
        found = 1'b1;
        pick = idx[2:0];
      end
    end
  end

  always_comb begin
    start = (state_q == IDLE) && found && (cnt_q < 8'(DEPTH));
    state_d = start ? ISSUE : (state_q == ISSUE) ? CAPTURE : IDLE;
    grant_d = start ? pick : grant_q;
    wr = (state_q == CAPTURE);
    pop = q_rd_en && (cnt_q != 8'd0);
    ch_rd_en = '0;
    for (int i = 0; i < NUM_CH; i++) ch_rd_en[i] = (state_q == ISSUE) && (grant_q == 3'(i));
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) if (grant_q == 3'(i)) sel = ch_rd_data[i*DATA_W +: DATA_W];
`ifdef TSU_MERGE_TAG_EN
    wr_data = {grant_q, sel};
`else
    wr_data = sel;
`endif
    head = mem_q[rptr_q];
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    cnt_d = cnt_q + 8'(wr) - 8'(pop);
    data_d = pop ? head[DATA_W-1:0] : data_q;
`ifdef TSU_MERGE_TAG_EN
    chan_d = pop ? head[FW-1 -: 3] : chan_q;
`endif
  end

  always_ff @(posedge q_rd_clk) begin
    if (!q_rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'(NUM_CH-1);
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef TSU_MERGE_TAG_EN
      chan_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef TSU_MERGE_TAG_EN
      chan_q  <= chan_d;
`endif
    end
  end

  // a reset on the capture edge abandons the fetch
  always_ff @(posedge q_rd_clk) begin
    if (q_rst_n && wr) mem_q[wptr_q] <= wr_data;
  end

  assign q_rd_stat = cnt_q;
  assign q_rd_data = data_q;
`ifdef TSU_MERGE_TAG_EN
  assign q_rd_chan = chan_q;
`endif
endmodule
